// File: rtl/mtm_alu_pkg.sv
// Shared constants and types for the mtm_Alu serial front end.
// Imported by the deserializer and the CRC4 helper.
package mtm_alu_pkg;

  localparam int WORD_BITS = 11;
  localparam int CRC_IN_W  = 68;

  localparam logic       FLAG_DATA = 1'b0;
  localparam logic       FLAG_CTL  = 1'b1;
  localparam logic [3:0] CRC_POLY  = 4'b0011;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FLAG,
    S_PAYLOAD,
    S_STOP
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } result_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC4 (x^4+x+1, init 0) over a 68-bit vector, MSB first.
// Also used by the ALU core on its output CRC path.
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic [CRC_IN_W-1:0] data_i,
  output logic [3:0]          crc_o
);

  logic [3:0] crc;
  logic       fb;

  always_comb begin
    crc = 4'd0;
    fb  = 1'b0;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      fb  = crc[3] ^ data_i[i];
      crc = {crc[2:0], 1'b0} ^ ({4{fb}} & CRC_POLY);
    end
  end

  assign crc_o = crc;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial input stage of mtm_Alu: frames 11-bit words from sin and
// emits a one-cycle strobe with operands/opcode or error flags.
module mtm_alu_deserializer #(
  parameter int DATA_WORDS = 8,
  parameter int WORD_BITS  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic [2:0]  err_flags,
  output logic        out_valid
);

  import mtm_alu_pkg::*;

  localparam int         PAY_BITS = WORD_BITS - 3;
  localparam int         DW       = DATA_WORDS * 8;
  localparam logic [3:0] WCNT_CTL = 4'(DATA_WORDS);
  localparam logic [3:0] WCNT_MAX = 4'(DATA_WORDS + 1);
  localparam logic [2:0] BIT_TOP  = 3'(PAY_BITS - 1);

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        flag_q, flag_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]  wcnt_q, wcnt_d;
  result_t     res_q, res_d;
  logic        valid_q, valid_d;

  logic [2:0]  op_rx;
  logic [3:0]  crc_rx;
  logic [3:0]  crc_calc;

  assign op_rx  = shreg_q[6:4];
  assign crc_rx = shreg_q[3:0];

  // Operand register already holds {B, A} when the CTL word lands.
  mtm_alu_crc4 u_crc4 (
    .data_i ({data_q[63:0], 1'b1, op_rx}),
    .crc_o  (crc_calc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      flag_q   <= 1'b0;
      shreg_q  <= 8'd0;
      data_q   <= '0;
      wcnt_q   <= 4'd0;
      res_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      flag_q   <= flag_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      wcnt_q   <= wcnt_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    flag_d   = flag_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    wcnt_d   = wcnt_q;
    res_d    = res_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_START;
      end
      S_START: begin
        flag_d   = sin;
        bitcnt_d = BIT_TOP;
        state_d  = S_FLAG;
      end
      S_FLAG: begin
        shreg_d  = {shreg_q[6:0], sin};
        bitcnt_d = bitcnt_q - 3'd1;
        state_d  = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        shreg_d  = {shreg_q[6:0], sin};
        bitcnt_d = bitcnt_q - 3'd1;
        if (bitcnt_q == 3'd0) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          // Framing error: drop the packet, keep operands.
          wcnt_d              = 4'd0;
          res_d.err           = 3'b000;
          res_d.err[ERR_DATA] = 1'b1;
          valid_d             = 1'b1;
        end else if (flag_q == FLAG_CTL) begin
          res_d.b   = data_q[DW-1 -: 32];
          res_d.a   = data_q[31:0];
          res_d.op  = op_rx;
          res_d.err = 3'b000;
          if (wcnt_q != WCNT_CTL) begin
            res_d.err[ERR_DATA] = 1'b1;
          end else begin
            res_d.err[ERR_CRC] = (crc_calc != crc_rx);
            res_d.err[ERR_OP]  = !op_legal(op_rx);
          end
          wcnt_d  = 4'd0;
          valid_d = 1'b1;
        end else begin
          data_d = {data_q[DW-9:0], shreg_q};
          if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A         = res_q.a;
  assign B         = res_q.b;
  assign op        = res_q.op;
  assign err_flags = res_q.err;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: vector table of packets
// plus framing-error and mid-packet reset sequences.
module tb_mtm_alu_deserializer;

  localparam time PER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] A, B;
  logic [2:0]  op, err_flags;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  int          pulses = 0;
  logic        prev_v = 1'b0;
  logic [31:0] cap_a, cap_b;
  logic [2:0]  cap_op, cap_err;
  time         t_pulse = 0;
  time         t_stop = 0;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .A         (A),
    .B         (B),
    .op        (op),
    .err_flags (err_flags),
    .out_valid (out_valid)
  );

  always #(PER / 2) clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      cap_a   = A;
      cap_b   = B;
      cap_op  = op;
      cap_err = err_flags;
      t_pulse = $time;
      checks++;
      if (prev_v) begin
        errors++;
        $display("FAIL strobe_width: got 2 consecutive cycles, required 1");
      end
    end
    prev_v = out_valid;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Remainder of M(x)*x^4 mod (x^4+x+1) by long division.
  function automatic logic [3:0] crc4_model(input logic [31:0] b,
                                            input logic [31:0] a,
                                            input logic [2:0] o);
    logic [71:0] m;
    m = {b, a, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic send_word(input logic flag, input logic [7:0] byt,
                           input logic stopb);
    send_bit(1'b0);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(byt[i]);
    t_stop = $time;
    send_bit(stopb);
  endtask

  task automatic send_packet(input int nw, input logic [31:0] b,
                             input logic [31:0] a, input logic [2:0] o,
                             input logic [3:0] crc);
    logic [63:0] d;
    int          k0;
    d  = {b, a};
    k0 = (nw >= 8) ? 0 : 8 - nw;
    if (nw > 8) send_word(1'b0, 8'hA5, 1'b1);
    for (int k = k0; k < 8; k++) send_word(1'b0, d[63 - 8 * k -: 8], 1'b1);
    send_word(1'b1, {1'b0, o, crc}, 1'b1);
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    int          nw;
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic        crc_inv;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          p0;
    logic [3:0]  c;
    logic [63:0] d;

    vecs[0] = '{"add_ok",   8, 32'h00000002, 32'h00000003, 3'b100, 1'b0, 3'b000};
    vecs[1] = '{"add_bcrc", 8, 32'h00000002, 32'h00000003, 3'b100, 1'b1, 3'b010};
    vecs[2] = '{"words7",   7, 32'h01020304, 32'h05060708, 3'b100, 1'b0, 3'b100};
    vecs[3] = '{"words9",   9, 32'h01020304, 32'h05060708, 3'b100, 1'b0, 3'b100};
    vecs[4] = '{"op111",    8, 32'hDEADBEEF, 32'h00C0FFEE, 3'b111, 1'b0, 3'b001};
    vecs[5] = '{"sub_ok",   8, 32'h12345678, 32'h9ABCDEF0, 3'b101, 1'b0, 3'b000};
    vecs[6] = '{"or_ok",    8, 32'hFFFFFFFF, 32'h80000001, 3'b001, 1'b0, 3'b000};
    vecs[7] = '{"op010bcr", 8, 32'h0000FFFF, 32'h55AA55AA, 3'b010, 1'b1, 3'b011};
    vecs[8] = '{"ctl_only", 0, 32'h00000000, 32'h00000000, 3'b000, 1'b0, 3'b100};

    rst = 1'b0;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_op", op, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_valid", out_valid, 0);
    rst = 1'b1;
    idle(3);

    foreach (vecs[i]) begin
      c = crc4_model(vecs[i].b, vecs[i].a, vecs[i].op);
      if (vecs[i].crc_inv) c = ~c;
      p0 = pulses;
      send_packet(vecs[i].nw, vecs[i].b, vecs[i].a, vecs[i].op, c);
      idle(3);
      chk({vecs[i].name, "_pulses"}, 64'(pulses - p0), 1);
      chk({vecs[i].name, "_latency"}, t_pulse - t_stop, PER);
      chk({vecs[i].name, "_err"}, cap_err, vecs[i].exp_err);
      chk({vecs[i].name, "_op"}, cap_op, vecs[i].op);
      if (!vecs[i].exp_err[2]) begin
        chk({vecs[i].name, "_A"}, cap_a, vecs[i].a);
        chk({vecs[i].name, "_B"}, cap_b, vecs[i].b);
      end
    end

    // Framing error on word 3, then a clean packet.
    p0 = pulses;
    send_word(1'b0, 8'h11, 1'b1);
    send_word(1'b0, 8'h22, 1'b1);
    send_word(1'b0, 8'h33, 1'b0);
    idle(3);
    chk("frame_pulses", 64'(pulses - p0), 1);
    chk("frame_latency", t_pulse - t_stop, PER);
    chk("frame_err", cap_err, 3'b100);
    p0 = pulses;
    c  = crc4_model(32'hCAFEF00D, 32'h00000007, 3'b100);
    send_packet(8, 32'hCAFEF00D, 32'h00000007, 3'b100, c);
    idle(3);
    chk("post_frame_pulses", 64'(pulses - p0), 1);
    chk("post_frame_err", cap_err, 3'b000);
    chk("post_frame_A", cap_a, 32'h00000007);
    chk("post_frame_B", cap_b, 32'hCAFEF00D);

    // Reset pulled during word 6.
    p0 = pulses;
    d  = 64'h1122334455667788;
    for (int k = 0; k < 5; k++) send_word(1'b0, d[63 - 8 * k -: 8], 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_A", A, 0);
    chk("midrst_B", B, 0);
    chk("midrst_op", op, 0);
    chk("midrst_err", err_flags, 0);
    chk("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(12);
    chk("midrst_pulses", 64'(pulses - p0), 0);
    p0 = pulses;
    c  = crc4_model(32'h0F0F0F0F, 32'hFFFF0000, 3'b000);
    send_packet(8, 32'h0F0F0F0F, 32'hFFFF0000, 3'b000, c);
    idle(3);
    chk("after_rst_pulses", 64'(pulses - p0), 1);
    chk("after_rst_err", cap_err, 3'b000);
    chk("after_rst_op", cap_op, 3'b000);
    chk("after_rst_A", cap_a, 32'hFFFF0000);
    chk("after_rst_B", cap_b, 32'h0F0F0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtm_alu_deserializer.md
Name: mtm_alu_deserializer

Overview:
- Serial input stage of the mtm_Alu datapath; decodes the `sin` bit stream into operands A, B and opcode for the ALU core.
- Checks packet structure, CRC4 and opcode legality; issues a one-cycle `out_valid` with either operands or error flags.
- Mirror of the output serializer: one bit per `clk`, same 11-bit word format.

Parameters:
- DATA_WORDS, 8, number of data words expected before the CTL word.
- WORD_BITS, 11, bits per serial word (start + flag + 8 payload + stop).

Ports:
- clk  input  1  system clock; `sin` sampled on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data in; idles high.
- A  output  32  operand A, assembled from words 5..8, MSB byte first.
- B  output  32  operand B, assembled from words 1..4, MSB byte first.
- op  output  3  opcode from the CTL word.
- err_flags  output  3  {err_data, err_crc, err_op}.
- out_valid  output  1  one-cycle strobe; A/B/op/err_flags are valid on it.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE; A = B = 0; op = 0; err_flags = 0; out_valid = 0; word count = 0.
  - Reset mid-packet discards the partial packet; no strobe is issued.
- Word format, MSB first:
  - start bit 0, then flag bit (0 = data, 1 = CTL), then 8 payload bits, then stop bit 1.
  - CTL payload = {1'b0, OP[2:0], CRC[3:0]}.
- FSM states: IDLE, START, FLAG, PAYLOAD, STOP.
  - IDLE -> START when `sin` = 0.
  - START -> FLAG: latch the flag bit on the next cycle.
  - FLAG -> PAYLOAD: shift 8 bits; a 3-bit bit counter runs from 7 down to 0.
  - PAYLOAD -> STOP after bit 0.
  - STOP -> IDLE; a new start bit can follow on the very next cycle (back-to-back words).
- Data word handling:
  - On a valid stop bit, shift the byte into a 64-bit {B,A} register.
  - Word count saturates at DATA_WORDS+1 = 9.
- CTL word handling, on a valid stop bit:
  - Count != 8: err_data = 1, err_crc = 0, err_op = 0.
  - Count == 8:
    - err_crc = (received CRC != CRC4 over {B, A, 1'b1, OP}, 68 bits, poly x^4+x+1, init 0).
    - err_op = OP not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
  - Drive A, B, op, err_flags and pulse `out_valid` on the cycle after the CTL stop bit is sampled.
  - Clear the word count.
- Stop bit sampled as 0 (framing error):
  - Abort the packet, clear the word count, return to IDLE.
  - Pulse `out_valid` with err_data = 1.
- Outputs hold their last values between strobes; `out_valid` is never high on two consecutive cycles.
- A CTL word arriving as the first word of a packet (count 0) is an err_data packet.
- Latency: `out_valid` asserts 1 cycle after the CTL stop bit (11 cycles after the CTL start bit is sampled).

Decomposition:
- Package mtm_alu_pkg holds:
  - opcode constants (AND/OR/ADD/SUB);
  - err_flags bit indices;
  - WORD_BITS, the CTL flag value, and the CRC4 polynomial.
- Sub-module mtm_alu_crc4: combinational CRC4 over a 68-bit vector. It is shared with the ALU core's output CRC path.

Test Plan:
- Valid ADD, B = 0x00000002, A = 0x00000003, OP = 100, correct CRC from the bench crc4 model -> one `out_valid`; A = 3, B = 2, op = 100, err_flags = 000.
- Same packet with CRC bits inverted -> `out_valid`; err_flags = 010; A and B still updated.
- 7 data words then CTL -> err_flags = 100; 9 data words then CTL -> err_flags = 100.
- Correct CRC with OP = 111 -> err_flags = 001.
- Stop bit forced to 0 in word 3 -> `out_valid` with err_flags = 100 at that word's stop; a following valid packet decodes correctly.
- `rst` pulled low during word 6 -> no `out_valid`, all outputs 0; the next full valid packet (AND, A = 0xFFFF0000, B = 0x0F0F0F0F) decodes with err_flags = 000.
